// File: rtl/pwm_duty_meter.sv
// Recovers the 8-bit PWM code from a sampled waveform with period-tolerance
// checking and stuck-line detection.
module pwm_duty_meter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PERIOD      = 256,
   parameter int unsigned TOL         = 4,
   parameter int unsigned TIMEOUT     = 1023,
   localparam int unsigned CW         = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          pwm_in,
   output logic [7:0]    duty,
   output logic          duty_valid,
   output logic [CW-1:0] period,
   output logic          period_err,
   output logic          stuck_hi,
   output logic          stuck_lo
);

   localparam logic [CW-1:0] LP_TIMEOUT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LP_PER_MIN = CW'(PERIOD - TOL);
   localparam logic [CW-1:0] LP_PER_MAX = CW'(PERIOD + TOL);
   localparam logic [CW-1:0] LP_ONE     = CW'(1);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HIGH, S_LOW, S_STUCK} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic                   r_rise;
   logic                   r_fall;
   logic [CW-1:0]          r_per_cnt;
   logic [CW-1:0]          r_hi_cnt;
   logic [CW-1:0]          r_quiet_cnt;
   logic [7:0]             r_duty;
   logic                   r_valid;
   logic [CW-1:0]          r_period;
   logic                   r_err;
   logic                   r_shi;
   logic                   r_slo;

   logic                   w_s;
   logic                   w_timeout;
   logic                   w_in_tol;
   logic [CW-1:0]          w_hi_m1;
   logic [7:0]             w_duty_calc;
   logic                   w_start;
   logic                   w_stuck;
   logic [CW-1:0]          w_per_nxt;
   logic [CW-1:0]          w_hi_nxt;
   logic [CW-1:0]          w_quiet_nxt;
   logic [7:0]             w_duty_nxt;
   logic                   w_valid_nxt;
   logic [CW-1:0]          w_period_nxt;
   logic                   w_err_nxt;
   logic                   w_shi_nxt;
   logic                   w_slo_nxt;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= LP_TIMEOUT) ? LP_TIMEOUT : v + LP_ONE;
   endfunction

   assign w_s = r_sync[SYNC_STAGES-1];

   // Edges are registered, so r_s_d is the line level aligned with r_rise/r_fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
         r_s_d  <= w_s;
         r_rise <= w_s & ~r_s_d;
         r_fall <= ~w_s & r_s_d;
      end
   end

   assign w_timeout   = (r_per_cnt >= LP_TIMEOUT) || (r_quiet_cnt >= LP_TIMEOUT);
   assign w_in_tol    = (r_per_cnt >= LP_PER_MIN) && (r_per_cnt <= LP_PER_MAX);
   assign w_hi_m1     = r_hi_cnt - LP_ONE;
   assign w_duty_calc = (w_hi_m1 > CW'(255)) ? 8'hFF : w_hi_m1[7:0];

   always_comb begin
      w_state_nxt  = r_state;
      w_per_nxt    = r_per_cnt;
      w_hi_nxt     = r_hi_cnt;
      w_quiet_nxt  = (r_rise | r_fall) ? LP_ONE : sat_inc(r_quiet_cnt);
      w_duty_nxt   = r_duty;
      w_valid_nxt  = 1'b0;
      w_period_nxt = r_period;
      w_err_nxt    = r_err;
      w_shi_nxt    = r_shi;
      w_slo_nxt    = r_slo;
      w_start      = 1'b0;
      w_stuck      = 1'b0;

      if (en) begin
         w_state_nxt  = S_IDLE;
         w_per_nxt    = '0;
         w_hi_nxt     = '0;
         w_quiet_nxt  = '0;
         w_duty_nxt   = '0;
         w_period_nxt = '0;
         w_err_nxt    = 1'b0;
         w_shi_nxt    = 1'b0;
         w_slo_nxt    = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_SYNC;
               w_quiet_nxt = '0;
            end
            S_SYNC: begin
               if (r_rise)         w_start = 1'b1;
               else if (w_timeout) w_stuck = 1'b1;
            end
            S_HIGH: begin
               if (r_fall) begin
                  w_state_nxt = S_LOW;
                  w_per_nxt   = sat_inc(r_per_cnt);
               end else if (w_timeout) begin
                  w_stuck = 1'b1;
               end else begin
                  w_per_nxt = sat_inc(r_per_cnt);
                  w_hi_nxt  = sat_inc(r_hi_cnt);
               end
            end
            S_LOW: begin
               if (r_rise) begin
                  w_start      = 1'b1;
                  w_period_nxt = r_per_cnt;
                  if (w_in_tol) begin
                     w_duty_nxt  = w_duty_calc;
                     w_valid_nxt = 1'b1;
                     w_err_nxt   = 1'b0;
                  end else begin
                     w_err_nxt   = 1'b1;
                  end
               end else if (w_timeout) begin
                  w_stuck = 1'b1;
               end else begin
                  w_per_nxt = sat_inc(r_per_cnt);
               end
            end
            S_STUCK: begin
               if (r_rise) begin
                  w_start   = 1'b1;
                  w_shi_nxt = 1'b0;
                  w_slo_nxt = 1'b0;
               end else if (r_fall) begin
                  w_state_nxt = S_SYNC;
                  w_per_nxt   = '0;
                  w_hi_nxt    = '0;
                  w_shi_nxt   = 1'b0;
                  w_slo_nxt   = 1'b0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase

         if (w_start) begin
            w_state_nxt = S_HIGH;
            w_per_nxt   = LP_ONE;
            w_hi_nxt    = LP_ONE;
         end
         if (w_stuck) begin
            w_state_nxt = S_STUCK;
            w_shi_nxt   = r_s_d;
            w_slo_nxt   = ~r_s_d;
            w_duty_nxt  = r_s_d ? 8'hFF : 8'h00;
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_per_cnt   <= '0;
         r_hi_cnt    <= '0;
         r_quiet_cnt <= '0;
         r_duty      <= '0;
         r_valid     <= 1'b0;
         r_period    <= '0;
         r_err       <= 1'b0;
         r_shi       <= 1'b0;
         r_slo       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_per_cnt   <= w_per_nxt;
         r_hi_cnt    <= w_hi_nxt;
         r_quiet_cnt <= w_quiet_nxt;
         r_duty      <= w_duty_nxt;
         r_valid     <= w_valid_nxt;
         r_period    <= w_period_nxt;
         r_err       <= w_err_nxt;
         r_shi       <= w_shi_nxt;
         r_slo       <= w_slo_nxt;
      end
   end

   assign duty       = r_duty;
   assign duty_valid = r_valid;
   assign period     = r_period;
   assign period_err = r_err;
   assign stuck_hi   = r_shi;
   assign stuck_lo   = r_slo;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: table of PWM periods plus stuck, enable and
// asynchronous-reset sequences, checked through an expected-result queue.
module tb_pwm_duty_meter;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned PERIOD      = 256;
   localparam int unsigned TOL         = 4;
   localparam int unsigned TIMEOUT     = 1023;
   localparam int unsigned CW          = 10;
   localparam int unsigned LAT         = SYNC_STAGES + 2;

   logic          clk     = 1'b0;
   logic          clk_run = 1'b1;
   logic          rst_n   = 1'b0;
   logic          en      = 1'b0;
   logic          pwm_in  = 1'b0;
   logic [7:0]    duty;
   logic          duty_valid;
   logic [CW-1:0] period;
   logic          period_err;
   logic          stuck_hi;
   logic          stuck_lo;

   int unsigned cyc   = 0;
   int          n_chk = 0;
   int          n_err = 0;

   typedef struct {
      int unsigned hi;
      int unsigned lo;
      logic [7:0]  duty;
      logic [9:0]  per;
      logic        err;
   } vec_t;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  duty;
      logic [9:0]  per;
      logic        err;
      logic        shi;
      logic        slo;
   } exp_t;

   exp_t       vq[$];
   exp_t       sq[$];
   vec_t       prev;
   bit         prev_open = 1'b0;
   logic [9:0] m_per     = '0;

   pwm_duty_meter #(
      .SYNC_STAGES(SYNC_STAGES),
      .PERIOD     (PERIOD),
      .TOL        (TOL),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pwm_in    (pwm_in),
      .duty      (duty),
      .duty_valid(duty_valid),
      .period    (period),
      .period_err(period_err),
      .stuck_hi  (stuck_hi),
      .stuck_lo  (stuck_lo)
   );

   always #5 if (clk_run) clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] outs();
      return 32'({duty, duty_valid, period, period_err, stuck_hi, stuck_lo});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just before a rise is driven: that rise closes the open period.
   task automatic close_prev();
      exp_t e;
      if (prev_open) begin
         m_per  = prev.per;
         e.duty = prev.duty;
         e.per  = prev.per;
         e.err  = prev.err;
         e.shi  = 1'b0;
         e.slo  = 1'b0;
         if (!prev.err) begin
            e.cyc = cyc + LAT;
            vq.push_back(e);
         end else begin
            e.cyc = cyc + LAT + 2;
            sq.push_back(e);
         end
      end
   endtask

   task automatic drive_row(input vec_t v);
      close_prev();
      pwm_in    = 1'b1;
      prev      = v;
      prev_open = 1'b1;
      tick(v.hi);
      pwm_in = 1'b0;
      tick(v.lo);
   endtask

   task automatic drive_stuck(input bit level, input int unsigned hi, input int unsigned lo);
      exp_t e;
      close_prev();
      pwm_in    = 1'b1;
      prev_open = 1'b0;
      e.cyc  = cyc + LAT + TIMEOUT;
      e.duty = level ? 8'hFF : 8'h00;
      e.per  = m_per;
      e.err  = 1'b0;
      e.shi  = level;
      e.slo  = !level;
      vq.push_back(e);
      tick(hi);
      if (level) chk("stuck_hi_set", 32'(stuck_hi), 1);
      pwm_in = 1'b0;
      tick(lo);
      if (level) chk("stuck_hi_clear", 32'(stuck_hi), 0);
      else       chk("stuck_lo_set", 32'(stuck_lo), 1);
   endtask

   always @(negedge clk) begin
      exp_t ev;
      exp_t es;
      if (duty_valid) begin
         if (vq.size() == 0) begin
            chk("unexpected_valid", 32'(duty_valid), 0);
         end else begin
            ev = vq.pop_front();
            chk("valid_cycle", cyc, ev.cyc);
            chk("valid_duty", 32'(duty), 32'(ev.duty));
            chk("valid_period", 32'(period), 32'(ev.per));
            chk("valid_period_err", 32'(period_err), 32'(ev.err));
            chk("valid_stuck_hi", 32'(stuck_hi), 32'(ev.shi));
            chk("valid_stuck_lo", 32'(stuck_lo), 32'(ev.slo));
         end
      end else if (vq.size() != 0 && cyc > vq[0].cyc) begin
         ev = vq.pop_front();
         chk("missing_valid", 32'(duty_valid), 1);
      end
      if (sq.size() != 0 && cyc >= sq[0].cyc) begin
         es = sq.pop_front();
         chk("err_period", 32'(period), 32'(es.per));
         chk("err_flag", 32'(period_err), 32'(es.err));
         chk("err_duty_held", 32'(duty), 32'(es.duty));
      end
   end

   initial begin
      vec_t tbl [13];
      vec_t nom;
      vec_t err300;
      //          hi   lo   duty    period   err
      tbl[0]  = '{101, 155, 8'd100, 10'd256, 1'b0};
      tbl[1]  = '{101, 155, 8'd100, 10'd256, 1'b0};
      tbl[2]  = '{  1, 255, 8'd0,   10'd256, 1'b0};
      tbl[3]  = '{255,   1, 8'd254, 10'd256, 1'b0};
      tbl[4]  = '{101, 199, 8'd254, 10'd300, 1'b1};
      tbl[5]  = '{101, 155, 8'd100, 10'd256, 1'b0};
      tbl[6]  = '{ 50, 210, 8'd49,  10'd260, 1'b0};
      tbl[7]  = '{200,  52, 8'd199, 10'd252, 1'b0};
      tbl[8]  = '{101, 160, 8'd199, 10'd261, 1'b1};
      tbl[9]  = '{101, 150, 8'd199, 10'd251, 1'b1};
      tbl[10] = '{258,   1, 8'd255, 10'd259, 1'b0};
      tbl[11] = '{ 10, 246, 8'd9,   10'd256, 1'b0};
      tbl[12] = '{101, 155, 8'd100, 10'd256, 1'b0};
      nom     = '{101, 155, 8'd100, 10'd256, 1'b0};
      err300  = '{101, 199, 8'd100, 10'd300, 1'b1};

      tick(3);
      chk("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      tick(5);

      for (int i = 0; i < 13; i++) drive_row(tbl[i]);

      drive_stuck(1'b1, 1100, 100);
      drive_row(nom);
      drive_row(nom);
      drive_row(err300);
      drive_stuck(1'b0, 101, 1100);
      drive_row(nom);
      drive_row(nom);

      // en abort in the middle of a high phase; the resumed partial period is discarded
      close_prev();
      pwm_in    = 1'b1;
      prev      = nom;
      prev_open = 1'b1;
      tick(30);
      en = 1'b1;
      tick(3);
      chk("idle_outputs", outs(), 0);
      prev_open = 1'b0;
      m_per     = '0;
      tick(20);
      en = 1'b0;
      tick(48);
      pwm_in = 1'b0;
      tick(155);
      drive_row(nom);
      drive_row(nom);

      // asynchronous reset mid-low with the clock stopped
      close_prev();
      pwm_in    = 1'b1;
      prev_open = 1'b0;
      tick(101);
      pwm_in = 1'b0;
      tick(50);
      chk("pre_reset_duty", 32'(duty), 100);
      clk_run = 1'b0;
      #2 rst_n = 1'b0;
      #2 chk("async_reset_outputs", outs(), 0);
      #2 rst_n = 1'b1;
      m_per = '0;
      #2 clk_run = 1'b1;
      tick(105);
      drive_row(nom);
      drive_row(nom);
      close_prev();
      pwm_in = 1'b1;
      tick(LAT + 8);
      chk("scoreboard_drained", 32'(vq.size() + sq.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
